// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory: VGA scanout has priority,
// but the CPU is guaranteed a slot after MAX_WAIT consecutive denied cycles.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflicts
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  owner_t     owner;
  logic [7:0] wait_cnt;
  logic       starved;

  assign starved = (wait_cnt == WAIT_MAX);

  // Grants are gated by reset so nothing reaches the memory while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!reset) begin
      cpu_gnt = cpu_req & (~vga_req | starved);
      vga_gnt = vga_req & ~cpu_gnt;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_addr  = vga_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_NONE;
      wait_cnt  <= '0;
      conflicts <= '0;
    end else begin
      if (cpu_gnt && !cpu_we)
        owner <= OWN_CPU;
      else if (vga_gnt)
        owner <= OWN_VGA;
      else
        owner <= OWN_NONE;

      if (cpu_req && !cpu_gnt)
        wait_cnt <= starved ? wait_cnt : wait_cnt + 8'd1;
      else
        wait_cnt <= '0;

      if (cpu_req && vga_req && conflicts != '1)
        conflicts <= conflicts + 16'd1;
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign vga_rvalid = (owner == OWN_VGA);
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   conflicts;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_starved = 0;
  int m_conf    = 0;
  bit m_crv     = 0;
  bit m_vrv     = 0;
  bit e_cg, e_vg;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // VGA wins contention unless the CPU has already been refused MW cycles in a row.
  task automatic model_eval();
    e_cg = cpu_req && (!vga_req || m_starved >= MW);
    e_vg = vga_req && !e_cg;
  endtask

  task automatic model_commit();
    m_crv = e_cg && !cpu_we;
    m_vrv = e_vg;
    if (cpu_req && !e_cg) m_starved = (m_starved + 1 > MW) ? MW : m_starved + 1;
    else                  m_starved = 0;
    if (cpu_req && vga_req && m_conf < 65535) m_conf++;
  endtask

  task automatic model_reset();
    m_starved = 0; m_conf = 0; m_crv = 0; m_vrv = 0;
  endtask

  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input logic vr, input logic [AW-1:0] va,
                      input logic [DW-1:0] rd);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vga_req = vr; vga_addr = va; mem_rdata = rd;
    #1;
    model_eval();
    check("cpu_gnt", 64'(cpu_gnt), 64'(e_cg));
    check("vga_gnt", 64'(vga_gnt), 64'(e_vg));
    check("mem_we", 64'(mem_we), 64'(e_cg & cw));
    check("mem_addr", 64'(mem_addr), e_cg ? 64'(ca) : (e_vg ? 64'(va) : 64'd0));
    check("mem_wdata", 64'(mem_wdata), e_cg ? 64'(cd) : 64'd0);
    check("cpu_rvalid", 64'(cpu_rvalid), 64'(m_crv));
    check("vga_rvalid", 64'(vga_rvalid), 64'(m_vrv));
    check("cpu_rdata", 64'(cpu_rdata), 64'(rd));
    check("vga_rdata", 64'(vga_rdata), 64'(rd));
    check("conflicts", 64'(conflicts), 64'(m_conf));
    model_commit();
  endtask

  task automatic idle(input logic [DW-1:0] rd);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, rd);
  endtask

  // Assert reset at a falling edge with both masters requesting; release just after a rising
  // edge so the very next rising edge is the first one that may grant.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hA5A5_A5A5;
    vga_req = 1'b1; vga_addr = 32'h1234_5678;
    #1;
    check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("rst_vga_gnt", 64'(vga_gnt), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("rst_vga_rvalid", 64'(vga_rvalid), 64'd0);
    check("rst_conflicts", 64'(conflicts), 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0;
  endtask

  initial begin
    do_reset();

    // CPU read at 0x40, immediately after reset release
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0);
    check("r30_gnt", 64'(cpu_gnt), 64'd1);
    idle(32'hDEAD_BEEF);
    check("r30_rvalid", 64'(cpu_rvalid), 64'd1);
    check("r30_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    check("r30_vga_rvalid", 64'(vga_rvalid), 64'd0);

    // CPU write
    step(1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    check("r31_we", 64'(mem_we), 64'd1);
    check("r31_addr", 64'(mem_addr), 64'h10);
    check("r31_wdata", 64'(mem_wdata), 64'h1234_5678);
    idle(32'h0);
    check("r31_no_crv", 64'(cpu_rvalid), 64'd0);
    check("r31_no_vrv", 64'(vga_rvalid), 64'd0);

    // Sustained contention: VGA 8 cycles, then CPU once, then VGA again
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h200 + i, 32'h0, 1'b1, 32'h800 + i, 32'h0);
      check("r32_cpu_gnt", 64'(cpu_gnt), (i == 8) ? 64'd1 : 64'd0);
      check("r32_vga_gnt", 64'(vga_gnt), (i == 8) ? 64'd0 : 64'd1);
    end
    idle(32'h0);
    check("r32_conflicts", 64'(conflicts), 64'd10);

    // Alternating CPU read / VGA read back to back
    step(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 32'h0);
    check("r33_cpu_gnt", 64'(cpu_gnt), 64'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h88, 32'h1111_2222);
    check("r33_vga_gnt", 64'(vga_gnt), 64'd1);
    check("r33_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    idle(32'h3333_4444);
    check("r33_vga_rvalid", 64'(vga_rvalid), 64'd1);
    check("r33_vga_rdata", 64'(vga_rdata), 64'h3333_4444);

    // Reset one cycle after a VGA read grant drops the pending read
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h90, 32'h0);
    check("r34_vga_gnt", 64'(vga_gnt), 64'd1);
    do_reset();
    idle(32'h5555_6666);
    check("r34_vga_rvalid", 64'(vga_rvalid), 64'd0);
    check("r34_conflicts", 64'(conflicts), 64'd0);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), $urandom, $urandom);

    // Saturation of the conflict counter
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; vga_req = 1'b1;
    for (int unsigned i = 0; i < 65535; i++) begin
      #1;
      model_eval();
      model_commit();
      @(negedge clk);
    end
    #1;
    check("r35_preload", 64'(conflicts), 64'hFFFF);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
    idle(32'h0);
    check("r35_saturated", 64'(conflicts), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 8, consecutive CPU denied cycles before forced CPU grant (range 1-255).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cpu_req/cpu_we  input  1 each  CPU access request / write strobe.
REQ-007 SHALL have ports cpu_addr  input  AW, cpu_wdata  input  DW  CPU address / write data.
REQ-008 SHALL have ports cpu_gnt  output  1, cpu_rvalid  output  1, cpu_rdata  output  DW  CPU grant / read-data valid / read data.
REQ-009 SHALL have ports vga_req  input  1, vga_addr  input  AW  VGA scanout read request and address (read-only).
REQ-010 SHALL have ports vga_gnt  output  1, vga_rvalid  output  1, vga_rdata  output  DW  VGA grant / read valid / read data.
REQ-011 SHALL have ports mem_we  output  1, mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW  single-port dmem, synchronous read, 1-cycle latency.
REQ-012 SHALL have port conflicts  output  16  saturating count of cycles with both requests active.

Function
REQ-013 SHALL decide grant combinationally each cycle from cpu_req, vga_req and the wait counter; at most one grant asserted per cycle.
REQ-014 SHALL grant VGA when only vga_req is set; CPU when only cpu_req is set.
REQ-015 SHALL grant VGA when both request, unless wait_cnt == MAX_WAIT, then grant CPU.
REQ-016 SHALL keep 8-bit wait_cnt: +1 (saturating at MAX_WAIT) each cycle cpu_req is set and cpu_gnt is clear; cleared to 0 on any cycle cpu_gnt is set or cpu_req is clear.
REQ-017 SHALL drive mem_addr/mem_we/mem_wdata from the granted requester in the grant cycle; mem_we = cpu_we & cpu_gnt; VGA grant forces mem_we=0.
REQ-018 SHALL drive mem_addr=0, mem_we=0, mem_wdata=0 in cycles with no grant.
REQ-019 SHALL register the read owner (NONE/CPU/VGA) at each grant; CPU write grants register NONE.
REQ-020 SHALL assert exactly one of cpu_rvalid/vga_rvalid for one cycle, the cycle after a read grant, per registered owner.
REQ-021 SHALL drive cpu_rdata and vga_rdata directly from mem_rdata every cycle; only rvalid qualifies them.
REQ-022 SHALL allow back-to-back grants every cycle, including alternating owners, with no bubble.
REQ-023 SHALL treat a requester as holding its request until it samples gnt=1; a request withdrawn before grant is dropped without side effect.
REQ-024 SHALL increment conflicts each cycle cpu_req & vga_req, saturating at 16'hFFFF.
REQ-025 SHALL resolve same-cycle grant and owner-register update on one edge, so rvalid for the previous grant and a new grant may coexist.

Reset
REQ-026 SHALL on reset assertion immediately clear: owner=NONE, wait_cnt=0, conflicts=0, cpu_rvalid=0, vga_rvalid=0.
REQ-027 SHALL, during reset, hold cpu_gnt=0, vga_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 SHALL drop any read in flight when reset asserts mid-operation; no rvalid after reset release for pre-reset grants.
REQ-029 SHALL accept requests in the first clock edge after reset deasserts.

Verification
REQ-030 SHALL verify: cpu_req=1, cpu_we=0, cpu_addr=0x40, mem returns 0xDEADBEEF -> cpu_gnt=1 cycle 0, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF cycle 1, vga_rvalid=0.
REQ-031 SHALL verify: CPU write to 0x10 data 0x12345678 -> mem_we=1, mem_addr=0x10, mem_wdata=0x12345678 same cycle; no rvalid next cycle.
REQ-032 SHALL verify: both request continuously, MAX_WAIT=8 -> VGA granted 8 cycles, CPU granted cycle 9, wait_cnt=0, VGA granted cycle 10; conflicts=9 after cycle 9.
REQ-033 SHALL verify: alternating CPU read then VGA read on consecutive cycles -> cpu_rvalid cycle 1, vga_rvalid cycle 2, no idle cycles.
REQ-034 SHALL verify: reset asserted asynchronously one cycle after VGA read grant -> vga_rvalid stays 0, all outputs zero, conflicts=0.
REQ-035 SHALL verify: conflicts preloaded by 65535 contending cycles then one more contention -> conflicts stays 16'hFFFF.
